uart_msg_streamer: RTL and testbench
====================================

# uart_msg_streamer

Single-clock UART message streamer: holds a writable message buffer of up to MSG_DEPTH bytes and transmits it as 8N1 frames on `tx`, once or repeatedly, with a configurable idle gap between repetitions. Generates its own baud timing as a clock-enable from the system clock, so no derived clock domain exists. Sits between board-level control logic (buttons, host CSRs) and the UART TX pin. It supersedes the fixed-string, fixed-9600-baud transmitter loop in the board tops.

## Interface
- CLK_DIV, 1250, system clocks per bit time (12 MHz / 9600); legal ≥ 2
- MSG_DEPTH, 16, message buffer depth in bytes; power of two, ≥ 2
- GAP_BITS, 4, idle bit times inserted between repetitions in loop mode; 0 allowed
- ADDR_W, $clog2(MSG_DEPTH), derived; not overridden
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_W  buffer write address
- wr_data  in  8  buffer write byte
- msg_len  in  ADDR_W+1  characters per message; sampled on accepted `start`
- start  in  1  begin transmission; level-sampled, accepted only in IDLE
- loop  in  1  repeat message; sampled at end of each message
- abort  in  1  stop transmission immediately
- tx  out  1  serial line, idle high
- busy  out  1  high in every state except IDLE
- char_done  out  1  one-cycle pulse at end of each stop bit
- msg_done  out  1  one-cycle pulse at end of the last character of a message
- cur_idx  out  ADDR_W  buffer index of the character in flight

## Operation
- States: IDLE, LOAD, START, DATA, PARITY (macro only), STOP, GAP.
- IDLE: `tx`=1, baud counter held at 0. `start` with `msg_len`≠0 → latch length (clamped to MSG_DEPTH), index=0 → LOAD. `start` with `msg_len`=0: ignored, busy stays 0.
- LOAD (1 cycle): shift register ← buffer[index] → START.
- START: `tx`=0 for one bit → DATA. DATA: 8 bits, LSB first → STOP. STOP: `tx`=1 for one bit, `char_done` pulses on its final cycle.
- After STOP: index+1 < length → index+1, LOAD. Else pulse `msg_done`; `loop`=1 → index=0, GAP (GAP_BITS=0 goes straight to LOAD); `loop`=0 → IDLE.
- GAP: `tx`=1 for GAP_BITS bit times → LOAD.
- Bit timer: counter 0..CLK_DIV-1, bit_tick at CLK_DIV-1, reset on every state entry.
- Buffer: written any time; byte read at LOAD, so writes to not-yet-loaded indices take effect in the current message. Write and LOAD at same address same cycle: LOAD gets the old byte.
- `start` while busy: ignored. `abort` (priority over all): next cycle IDLE, `tx`=1, no `char_done`/`msg_done`.
- Reset: state IDLE, `tx`=1, `busy`=0, `char_done`=0, `msg_done`=0, `cur_idx`=0, counters 0. Buffer contents not reset.

## Timing
- `start` accepted at edge N: LOAD during N+1, `tx` falls at N+2.
- Each bit exactly CLK_DIV cycles; frame 10·CLK_DIV (11·CLK_DIV with parity).
- Character-to-character spacing: frame + 1 cycle (LOAD).
- Loop spacing: last stop end to next start bit = GAP_BITS·CLK_DIV + 1 cycles.
- `msg_done` coincides with the last `char_done`. `busy` falls the cycle after.
- `tx` is a registered output, glitch-free.

## Configuration
- `UART_MSG_PARITY_EN` defined: PARITY state inserted after DATA, sending even parity of the 8 data bits; frame becomes 8E1, 11 bit times.
- Undefined: no PARITY state, 8N1 only, 10 bit times.

## Structure
- Package `uart_pkg`: state enum `uart_tx_state_t`, frame length constants (`UART_DATA_BITS`=8, `UART_FRAME_BITS` per macro), default `CLK_DIV` for 12 MHz/9600.
- Sub-module `uart_tx_core`: baud counter + shift register + START/DATA/PARITY/STOP sequencing with byte/valid/done handshake. The streamer owns buffer, index, loop and gap logic.

## Test plan
- CLK_DIV=4, write "HI\n" at 0..2, msg_len=3, start, loop=0 → three frames 0x48,0x49,0x0A LSB first, 40+1 cycles apart, 3 `char_done`, 1 `msg_done`, busy returns 0.
- msg_len=0 + start → busy stays 0, `tx` stays 1 for 100 cycles.
- loop=1, GAP_BITS=4, msg_len=2 → 16+1 idle cycles between repetitions. Drop loop mid-message → stops after that message's `msg_done`.
- abort during DATA bit 3 → next cycle `tx`=1, busy=0, no pulses. New start works normally.
- rst_n low during STOP → next edge `tx`=1, all outputs at reset values. Buffer keeps its data, so a resend matches.
- With `UART_MSG_PARITY_EN`, send 0x07 → parity bit 1, frame 44 cycles at CLK_DIV=4. Send 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state types and frame constants for the UART message streamer.
// Frame length follows the UART_MSG_PARITY_EN macro (8N1 when undefined, 8E1 when defined).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } uart_tx_state_t;

  // Streamer-level phases; the frame itself is sequenced inside uart_tx_core.
  typedef enum logic [1:0] {
    MSG_IDLE,
    MSG_LOAD,
    MSG_FRAME,
    MSG_GAP
  } msg_phase_t;

  localparam int UART_DATA_BITS = 8;
`ifdef UART_MSG_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
`else
  localparam int UART_FRAME_BITS = 10;
`endif
  localparam int UART_DEFAULT_CLK_DIV = 1250;

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: baud timer, shift register and START/DATA/[PARITY]/STOP sequencing.
// Takes one byte per i_valid while idle; PARITY stage exists only with UART_MSG_PARITY_EN.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_abort,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_done,
  output logic       o_done_next
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

  uart_tx_state_t            r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [2:0]                r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;
  logic                      r_done;
`ifdef UART_MSG_PARITY_EN
  logic                      r_parity;
`endif
  logic                      w_tick;

  assign w_tick = (r_cnt == CNT_LAST);
  // One cycle ahead of the last STOP cycle, so done pulses can be registered.
  assign o_done_next = (r_state == ST_STOP) && (r_cnt == CNT_PRE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n || i_abort) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= o_done_next;
      if (r_state == ST_IDLE || w_tick) r_cnt <= '0;
      else                              r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        ST_IDLE: if (i_valid) begin
          r_shift <= i_byte;
`ifdef UART_MSG_PARITY_EN
          r_parity <= ^i_byte;
`endif
          r_tx    <= 1'b0;
          r_state <= ST_START;
        end
        ST_START: if (w_tick) begin
          r_tx    <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_bit   <= '0;
          r_state <= ST_DATA;
        end
        ST_DATA: if (w_tick) begin
          if (r_bit == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_MSG_PARITY_EN
            r_tx    <= r_parity;
            r_state <= ST_PARITY;
`else
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
`endif
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'(1);
          end
        end
`ifdef UART_MSG_PARITY_EN
        ST_PARITY: if (w_tick) begin
          r_tx    <= 1'b1;
          r_state <= ST_STOP;
        end
`endif
        ST_STOP: if (w_tick) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_tx   = r_tx;
  assign o_done = r_done;

endmodule

// File: rtl/uart_msg_streamer.sv
// uart_msg_streamer: streams a writable byte buffer as UART frames, once or looped with a gap.
// Optional even parity via UART_MSG_PARITY_EN (handled in uart_tx_core).
module uart_msg_streamer
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = UART_DEFAULT_CLK_DIV,
  parameter int MSG_DEPTH = 16,
  parameter int GAP_BITS  = 4,
  parameter int ADDR_W    = $clog2(MSG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              start,
  input  logic              loop,
  input  logic              abort,
  output logic              tx,
  output logic              busy,
  output logic              char_done,
  output logic              msg_done,
  output logic [ADDR_W-1:0] cur_idx
);

  localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam int                GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(MSG_DEPTH);

  logic [7:0]        r_mem [MSG_DEPTH];
  msg_phase_t        r_phase;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [GAP_W-1:0]  r_gap_bits;
  logic              r_busy;
  logic              r_msg_done;

  logic              w_load;
  logic              w_last;
  logic              w_char_done;
  logic              w_done_next;
  logic [7:0]        w_load_byte;

  // NOTE: the message buffer has no reset so it maps onto plain RAM; its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Read before this edge's write lands, so a same-address write reaches LOAD one message late.
  assign w_load      = (r_phase == MSG_LOAD);
  assign w_load_byte = r_mem[r_idx];
  assign w_last      = ({1'b0, r_idx} + (ADDR_W + 1)'(1)) >= r_len;

  uart_tx_core #(
    .CLK_DIV (CLK_DIV)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_abort     (abort),
    .i_valid     (w_load),
    .i_byte      (w_load_byte),
    .o_tx        (tx),
    .o_done      (w_char_done),
    .o_done_next (w_done_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      r_phase    <= MSG_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_baud_cnt <= '0;
      r_gap_bits <= '0;
      r_busy     <= 1'b0;
      r_msg_done <= 1'b0;
    end else begin
      r_msg_done <= w_done_next && w_last;
      case (r_phase)
        MSG_IDLE: if (start && msg_len != '0) begin
          r_len   <= (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_phase <= MSG_LOAD;
        end
        MSG_LOAD: r_phase <= MSG_FRAME;
        MSG_FRAME: if (w_char_done) begin
          if (!w_last) begin
            r_idx   <= r_idx + ADDR_W'(1);
            r_phase <= MSG_LOAD;
          end else begin
            r_idx <= '0;
            if (!loop) begin
              r_busy  <= 1'b0;
              r_phase <= MSG_IDLE;
            end else if (GAP_BITS == 0) begin
              r_phase <= MSG_LOAD;
            end else begin
              r_baud_cnt <= '0;
              r_gap_bits <= '0;
              r_phase    <= MSG_GAP;
            end
          end
        end
        MSG_GAP: if (r_baud_cnt == CNT_LAST) begin
          r_baud_cnt <= '0;
          if (r_gap_bits == GAP_LAST) r_phase <= MSG_LOAD;
          else                        r_gap_bits <= r_gap_bits + GAP_W'(1);
        end else begin
          r_baud_cnt <= r_baud_cnt + CNT_W'(1);
        end
        default: r_phase <= MSG_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign char_done = w_char_done;
  assign msg_done  = r_msg_done;
  assign cur_idx   = r_idx;

endmodule

// File: tb/tb_uart_msg_streamer.sv
// Bench for uart_msg_streamer: cycle-level message model with per-cycle compare, directed
// literal checks and randomized episodes. Parity expectations follow UART_MSG_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_msg_streamer;
  import uart_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int MSG_DEPTH = 16;
  localparam int GAP_BITS  = 4;
  localparam int ADDR_W    = 4;
  localparam int P         = UART_FRAME_BITS * CLK_DIV + 1;  // frame plus LOAD cycle
  localparam int GAP_CYC   = GAP_BITS * CLK_DIV;
`ifdef UART_MSG_PARITY_EN
  localparam int LIT_SPACING = 45;
  localparam int LIT_LOOP    = 61;
`else
  localparam int LIT_SPACING = 41;
  localparam int LIT_LOOP    = 57;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   msg_len;
  logic              start, loop, abort;
  logic              tx, busy, char_done, msg_done;
  logic [ADDR_W-1:0] cur_idx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int cd_cnt   = 0;
  int md_cnt   = 0;
  logic cmp_en = 1'b0;

  uart_msg_streamer #(
    .CLK_DIV   (CLK_DIV),
    .MSG_DEPTH (MSG_DEPTH),
    .GAP_BITS  (GAP_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .msg_len   (msg_len),
    .start     (start),
    .loop      (loop),
    .abort     (abort),
    .tx        (tx),
    .busy      (busy),
    .char_done (char_done),
    .msg_done  (msg_done),
    .cur_idx   (cur_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: position t counts cycles from the LOAD of character 0.
  int         m_mode = 0;  // 0 idle, 1 message, 2 gap
  int         m_t, m_g, m_len;
  logic [7:0] m_byte;
  logic [7:0] m_mem [MSG_DEPTH];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n || abort) m_mode = 0;
    else case (m_mode)
      0: if (start && msg_len != 0) begin
        m_len  = (msg_len > MSG_DEPTH) ? MSG_DEPTH : int'(msg_len);
        m_t    = 0;
        m_mode = 1;
      end
      1: begin
        if (m_t % P == 0) m_byte = m_mem[m_t / P];
        if (m_t == m_len * P - 1) begin
          if (!loop)             m_mode = 0;
          else if (GAP_CYC == 0) m_t = 0;
          else begin m_mode = 2; m_g = 0; end
        end else m_t++;
      end
      default: if (m_g == GAP_CYC - 1) begin m_mode = 1; m_t = 0; end else m_g++;
    endcase
    if (wr_en) m_mem[wr_addr] = wr_data;
  end

  always @(negedge clk) begin : compare
    logic e_tx, e_busy, e_cd, e_md;
    int   e_idx, k, o, b;
    if (cmp_en) begin
      e_tx = 1'b1; e_busy = (m_mode != 0); e_cd = 1'b0; e_md = 1'b0; e_idx = 0;
      if (m_mode == 1) begin
        k = m_t / P; o = m_t % P; e_idx = k;
        if (o != 0) begin
          b = (o - 1) / CLK_DIV;
          if (b == 0)                        e_tx = 1'b0;
          else if (b <= 8)                   e_tx = m_byte[b-1];
          else if (b == UART_FRAME_BITS - 1) e_tx = 1'b1;
          else                               e_tx = ^m_byte;
        end
        e_cd = (o == P - 1);
        e_md = e_cd && (k == m_len - 1);
      end
      check("cyc_tx", tx, e_tx);
      check("cyc_busy", busy, e_busy);
      check("cyc_char_done", char_done, e_cd);
      check("cyc_msg_done", msg_done, e_md);
      check("cyc_cur_idx", cur_idx, e_idx);
    end
  end

  always @(posedge clk) begin
    #2;
    if (char_done === 1'b1) cd_cnt++;
    if (msg_done === 1'b1)  md_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input int a, input int d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int len, input logic lp, output int ta);
    msg_len = (ADDR_W + 1)'(len); loop = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ta = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    check("idle_reached", busy, 0);
  endtask

  // Returns at the middle of the stop bit, after checking it is high.
  task automatic capture_frame(output logic [7:0] b, output int t0, output logic par);
    int n = 0;
    par = 1'b0;
    while (tx !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    check("frame_start_seen", (n < 3000), 1);
    t0 = cyc;
    repeat (CLK_DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      b[i] = tx;
    end
    if (UART_FRAME_BITS == 11) begin
      repeat (CLK_DIV) @(negedge clk);
      par = tx;
    end
    repeat (CLK_DIV) @(negedge clk);
    check("stop_bit_high", tx, 1);
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    logic       p0, p1, p2;
    int t0, t1, t2, ta, c_cd, c_md, n_bad, n_cyc;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_len = '0; start = 1'b0; loop = 1'b0; abort = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_char_done", char_done, 0);
    check("rst_msg_done", msg_done, 0);
    check("rst_cur_idx", cur_idx, 0);
    rst_n = 1'b1;

    for (int i = 0; i < MSG_DEPTH; i++) write_byte(i, int'($urandom_range(0, 255)));
    write_byte(0, 8'h48); write_byte(1, 8'h49); write_byte(2, 8'h0A);

    // "HI\n" once
    c_cd = cd_cnt; c_md = md_cnt;
    pulse_start(3, 1'b0, ta);
    check("load_tx_high", tx, 1);
    check("load_busy", busy, 1);
    capture_frame(b0, t0, p0);
    check("start_latency", t0 - ta, 1);
    capture_frame(b1, t1, p1);
    capture_frame(b2, t2, p2);
    check("hi_byte0", b0, 8'h48);
    check("hi_byte1", b1, 8'h49);
    check("hi_byte2", b2, 8'h0A);
    check("hi_spacing01", t1 - t0, LIT_SPACING);
    check("hi_spacing12", t2 - t1, LIT_SPACING);
    wait_idle(200);
    check("hi_char_done_count", cd_cnt - c_cd, 3);
    check("hi_msg_done_count", md_cnt - c_md, 1);

    // Zero length is ignored
    pulse_start(0, 1'b0, ta);
    n_bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b0 || tx !== 1'b1) n_bad++;
      @(negedge clk);
    end
    check("zero_len_quiet_cycles", n_bad, 0);

    // Loop of two characters, loop dropped during the second repetition
    c_cd = cd_cnt; c_md = md_cnt;
    pulse_start(2, 1'b1, ta);
    capture_frame(b0, t0, p0);
    capture_frame(b1, t1, p1);
    capture_frame(b2, t2, p2);
    loop = 1'b0;
    check("loop_spacing_char", t1 - t0, LIT_SPACING);
    check("loop_spacing_gap", t2 - t1, LIT_LOOP);
    check("loop_rep2_byte0", b2, 8'h48);
    wait_idle(400);
    check("loop_msg_done_count", md_cnt - c_md, 2);
    check("loop_char_done_count", cd_cnt - c_cd, 4);

    // Abort during data bit 3
    pulse_start(3, 1'b0, ta);
    repeat (18) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    c_cd = cd_cnt; c_md = md_cnt;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_cur_idx", cur_idx, 0);
    repeat (60) @(negedge clk);
    check("abort_no_char_done", cd_cnt - c_cd, 0);
    check("abort_no_msg_done", md_cnt - c_md, 0);
    pulse_start(3, 1'b0, ta);
    capture_frame(b0, t0, p0);
    capture_frame(b1, t1, p1);
    capture_frame(b2, t2, p2);
    check("after_abort_byte0", b0, 8'h48);
    check("after_abort_byte2", b2, 8'h0A);
    wait_idle(200);

    // Reset during STOP; buffer must survive
    pulse_start(1, 1'b0, ta);
    capture_frame(b0, t0, p0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_stop_tx", tx, 1);
    check("rst_stop_busy", busy, 0);
    check("rst_stop_char_done", char_done, 0);
    check("rst_stop_msg_done", msg_done, 0);
    check("rst_stop_cur_idx", cur_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(1, 1'b0, ta);
    capture_frame(b1, t1, p1);
    check("resend_after_reset", b1, 8'h48);
    wait_idle(200);

`ifdef UART_MSG_PARITY_EN
    write_byte(0, 8'h07); write_byte(1, 8'h03);
    pulse_start(2, 1'b0, ta);
    capture_frame(b0, t0, p0);
    capture_frame(b1, t1, p1);
    check("parity_07", p0, 1);
    check("parity_03", p1, 0);
    check("parity_spacing", t1 - t0, 45);
    wait_idle(200);
`endif

    // Randomized episodes against the model
    for (int ep = 0; ep < 25; ep++) begin
      n_cyc = int'($urandom_range(200, 900));
      loop  = 1'($urandom_range(0, 1));
      for (int c = 0; c < n_cyc; c++) begin
        wr_en   = ($urandom_range(0, 9) == 0);
        wr_addr = ADDR_W'($urandom);
        wr_data = 8'($urandom);
        start   = ($urandom_range(0, 19) == 0);
        msg_len = (ADDR_W + 1)'($urandom_range(0, 20));
        abort   = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 99) == 0) loop = ~loop;
        @(negedge clk);
      end
      wr_en = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
      wait_idle(2000);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
